// File: rtl/io_gpio_regs.sv
// Memory-mapped GPIO register block for the MIPS data bus: per-port output latch,
// synchronised input, and rising-edge interrupt pending/enable, with registered reads.
module io_gpio_regs #(
    parameter int                ADDR_W      = 32,
    parameter int                N_PORTS     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h400,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [31:0]            wtData,
    output logic [31:0]            rdData,
    output logic                   rdValid,
    output logic                   busErr,
    input  logic [N_PORTS*32-1:0]  gpio_in,
    output logic [N_PORTS*32-1:0]  gpio_out,
    output logic                   irq
);

    localparam int             PW        = ADDR_W - 4;
    localparam logic [PW-1:0]  N_PORTS_P = PW'(N_PORTS);

    // Bus handshake: every cycle with ce=1 is an accepted request (there is no
    // back-pressure); its response strobe (rdValid and/or busErr) follows exactly one cycle later.

    logic [ADDR_W-1:0]                 off;
    logic [PW-1:0]                     port_sel;
    logic [1:0]                        reg_sel;
    logic                              bad;
    logic                              wr_good;
    logic                              rd_good;
    logic [31:0]                       wmask;
    logic [31:0]                       rd_word;

    logic [SYNC_STAGES-1:0][N_PORTS*32-1:0] sync_q;
    logic [N_PORTS-1:0][31:0]          in_w;
    logic [N_PORTS-1:0][31:0]          prev_q;
    logic [N_PORTS-1:0][31:0]          edge_w;
    logic [N_PORTS-1:0][31:0]          clr_w;
    logic [N_PORTS-1:0][31:0]          out_q, out_d;
    logic [N_PORTS-1:0][31:0]          en_q, en_d;
    logic [N_PORTS-1:0][31:0]          pend_q, pend_d;

    logic [31:0]                       rd_data_q;
    logic                              rd_valid_q;
    logic                              bus_err_q;
    logic                              irq_q;

    assign off      = addr - BASE_ADDR;
    assign port_sel = off[ADDR_W-1:4];
    assign reg_sel  = off[3:2];
    // BASE_ADDR is 16-byte aligned, so off[1:0] equals addr[1:0].
    assign bad      = (addr < BASE_ADDR) || (port_sel >= N_PORTS_P) || (off[1:0] != 2'b00);
    assign wr_good  = ce && we && !bad;
    assign rd_good  = ce && !we && !bad;
    assign wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign in_w     = sync_q[SYNC_STAGES-1];
    assign edge_w   = in_w & ~prev_q;

    always_comb begin
        out_d   = out_q;
        en_d    = en_q;
        clr_w   = '0;
        pend_d  = pend_q;
        rd_word = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (port_sel == PW'(p)) begin
                if (wr_good) begin
                    case (reg_sel)
                        2'd0:    out_d[p] = (out_q[p] & ~wmask) | (wtData & wmask);
                        2'd2:    en_d[p]  = (en_q[p] & ~wmask) | (wtData & wmask);
                        2'd3:    clr_w[p] = wtData & wmask;
                        default: ;
                    endcase
                end
                case (reg_sel)
                    2'd0:    rd_word = out_q[p];
                    2'd1:    rd_word = in_w[p];
                    2'd2:    rd_word = en_q[p];
                    default: rd_word = pend_q[p];
                endcase
            end
            // A new edge wins over a same-cycle clear of that bit.
            pend_d[p] = (pend_q[p] & ~clr_w[p]) | edge_w[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= '0;
            out_q      <= '0;
            en_q       <= '0;
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q     <= in_w;
            out_q      <= out_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            rd_valid_q <= ce && !we;
            bus_err_q  <= ce && bad;
            irq_q      <= |(pend_q & en_q);
            if (rd_good) begin
                rd_data_q <= rd_word;
            end else if (ce && bad) begin
                rd_data_q <= '0;
            end
        end
    end

    assign rdData   = rd_data_q;
    assign rdValid  = rd_valid_q;
    assign busErr   = bus_err_q;
    assign irq      = irq_q;
    assign gpio_out = out_q;

endmodule

// File: tb/tb_io_gpio_regs.sv
// Directed-vector bench for io_gpio_regs: reset, byte lanes, input sync/edge/irq,
// clear/edge collision, bad accesses and back-to-back read throughput.
module tb_io_gpio_regs;

  localparam int          NP   = 4;
  localparam logic [31:0] BASE = 32'h400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce = 1'b0;
  logic              we = 1'b0;
  logic [3:0]        be = 4'h0;
  logic [31:0]       addr = '0;
  logic [31:0]       wt_data = '0;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              bus_err;
  logic [NP*32-1:0]  gpio_in = '0;
  logic [NP*32-1:0]  gpio_out;
  logic              irq;

  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] out_vals [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hDEAD_BEEF, 32'hCAFE_F00D};
  logic [31:0] en_vals  [4] = '{32'h0000_0001, 32'h0000_0080, 32'h0000_F0F0, 32'h0000_0000};

  io_gpio_regs #(
    .ADDR_W(32), .N_PORTS(NP), .BASE_ADDR(BASE), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr),
    .wtData(wt_data), .rdData(rd_data), .rdValid(rd_valid), .busErr(bus_err),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input int p, input int r);
    return BASE + 32'(p * 16 + r * 4);
  endfunction

  // driver tasks: inputs change 1ns after a posedge, outputs sampled there too
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    ce = 1'b1; we = 1'b1; addr = a; wt_data = d; be = b;
    tick(1);
    ce = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; we = 1'b0; addr = a; be = 4'h0;
    tick(1);
    ce = 1'b0;
    check_val({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    check_val({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    // 1. reset
    #6;
    check_val("rst_rdvalid", {31'b0, rd_valid}, 32'd0);
    check_val("rst_gpio_out", gpio_out[31:0], 32'd0);
    tick(2);
    rst = 1'b0;
    bus_write(ra(0, 0), 32'hFFFF_0000, 4'hF);
    ce = 1'b1; we = 1'b0; addr = ra(0, 0);
    tick(1);
    check_val("pre_rst_data", rd_data, 32'hFFFF_0000);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_rdvalid", {31'b0, rd_valid}, 32'd0);
    check_val("mid_rst_rddata", rd_data, 32'd0);
    check_val("mid_rst_gpio_out", gpio_out[31:0], 32'd0);
    check_val("mid_rst_irq", {31'b0, irq}, 32'd0);
    ce = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < 4; r++)
        read_check($sformatf("post_rst_p%0d_r%0d", p, r), ra(p, r), 32'd0);

    // 2. byte lanes
    bus_write(ra(0, 0), 32'hAABB_CCDD, 4'b1111);
    bus_write(ra(0, 0), 32'h1122_3344, 4'b0101);
    check_val("lanes_gpio_out", gpio_out[31:0], 32'hAA22_CC44);
    bus_write(ra(0, 0), 32'h0000_0000, 4'b0000);
    check_val("be0_noop", gpio_out[31:0], 32'hAA22_CC44);
    bus_write(ra(0, 1), 32'hFFFF_FFFF, 4'b1111);
    check_val("in_write_noerr", {31'b0, bus_err}, 32'd0);
    check_val("idle_rdvalid", {31'b0, rd_valid}, 32'd0);
    read_check("lanes_read", ra(0, 0), 32'hAA22_CC44);
    tick(1);
    check_val("strobe_drop", {31'b0, rd_valid}, 32'd0);
    check_val("rddata_hold", rd_data, 32'hAA22_CC44);

    // 3. sync / edge / irq
    bus_write(ra(1, 2), 32'h0000_0008, 4'hF);
    gpio_in[35] = 1'b1;
    read_check("in1_early", ra(1, 1), 32'd0);
    check_val("irq_early1", {31'b0, irq}, 32'd0);
    read_check("pend1_early", ra(1, 3), 32'd0);
    read_check("in1_sync", ra(1, 1), 32'h0000_0008);
    check_val("irq_early2", {31'b0, irq}, 32'd0);
    read_check("pend1_set", ra(1, 3), 32'h0000_0008);
    check_val("irq_set", {31'b0, irq}, 32'd1);
    bus_write(ra(1, 3), 32'h0000_0008, 4'hF);
    check_val("irq_after_w1c_1", {31'b0, irq}, 32'd1);
    tick(1);
    check_val("irq_after_w1c_2", {31'b0, irq}, 32'd0);
    read_check("pend1_clr", ra(1, 3), 32'd0);

    // 4. clear/edge collision on port 2 bit 0
    gpio_in[64] = 1'b1;
    tick(2);
    gpio_in[64] = 1'b0;
    tick(2);
    gpio_in[64] = 1'b1;
    read_check("pend2_first", ra(2, 3), 32'h0000_0001);
    tick(1);
    bus_write(ra(2, 3), 32'h0000_0001, 4'hF);
    read_check("pend2_collide", ra(2, 3), 32'h0000_0001);
    bus_write(ra(2, 3), 32'h0000_0001, 4'hF);
    read_check("pend2_clear", ra(2, 3), 32'd0);

    // 5. bad accesses
    read_check("err_pre", ra(0, 0), 32'hAA22_CC44);
    bus_write(BASE + 32'd64, 32'hFFFF_FFFF, 4'hF);
    check_val("err_port_buserr", {31'b0, bus_err}, 32'd1);
    check_val("err_port_rdvalid", {31'b0, rd_valid}, 32'd0);
    ce = 1'b1; we = 1'b0; addr = BASE + 32'd2;
    tick(1);
    ce = 1'b0;
    check_val("err_align_buserr", {31'b0, bus_err}, 32'd1);
    check_val("err_align_rdvalid", {31'b0, rd_valid}, 32'd1);
    check_val("err_align_rddata", rd_data, 32'd0);
    bus_write(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF);
    check_val("err_low_buserr", {31'b0, bus_err}, 32'd1);
    bus_write(BASE + 32'd1, 32'h0000_0000, 4'hF);
    check_val("err_mis_wr_buserr", {31'b0, bus_err}, 32'd1);
    check_val("err_nochange_out", gpio_out[31:0], 32'hAA22_CC44);
    tick(1);
    check_val("err_strobe_drop", {31'b0, bus_err}, 32'd0);
    read_check("err_nochange_en1", ra(1, 2), 32'h0000_0008);

    // 6. throughput: 8 back-to-back reads
    for (int p = 0; p < NP; p++) begin
      bus_write(ra(p, 0), out_vals[p], 4'hF);
      bus_write(ra(p, 2), en_vals[p], 4'hF);
    end
    check_val("tp_gpio_out3", gpio_out[127:96], 32'hCAFE_F00D);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i % 2) ? en_vals[i / 2] : out_vals[i / 2]);
      ce = 1'b1; we = 1'b0; addr = ra(i / 2, (i % 2) ? 2 : 0);
      tick(1);
      check_val($sformatf("tp_valid_%0d", i), {31'b0, rd_valid}, 32'd1);
      check_val($sformatf("tp_data_%0d", i), rd_data, exp_q.pop_front());
    end
    ce = 1'b0;
    tick(1);
    check_val("tp_end_rdvalid", {31'b0, rd_valid}, 32'd0);
    check_val("final_irq", {31'b0, irq}, 32'd0);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
